// File: rtl/bottle_batch_counter.sv
// rtl/bottle_batch_counter.sv - BCD bottle batch counter with synchronised sensor input
// Counts sensor rising edges from START up to a BCD target, flagging near-completion, completion and faults.
module bottle_batch_counter #(
  parameter int DIGITS  = 2,
  parameter int START   = 1,
  parameter int PRE_GAP = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_change,
  input  logic [4*DIGITS-1:0]   i_target,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_pre_over,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int W  = 4 * DIGITS;
  localparam int BW = $clog2(10 ** DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [W-1:0]    r_count;
  logic [W-1:0]    w_nxt_count;
  logic [W-1:0]    w_count_inc;
  logic [BW-1:0]   r_remain;
  logic [BW-1:0]   w_nxt_remain;
  logic [BW-1:0]   w_tgt_bin;
  logic            w_tgt_valid;
  logic            r_err;
  logic            w_nxt_err;
  logic            r_pre_over;
  logic            r_done;
  logic            r_busy;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_sync3;
  logic [2:0]      r_arm;
  logic            r_inc;
  logic            w_edge;

  // Edges are only trusted once the whole chain has refilled after reset,
  // so a level already high at release is never mistaken for a bottle.
  assign w_edge = r_sync2 & ~r_sync3 & r_arm[2];

  always_comb begin
    int  acc;
    logic ok;
    acc = 0;
    ok  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i_target[4*i +: 4] > 4'd9) ok = 1'b0;
      acc = acc * 10 + int'(i_target[4*i +: 4]);
    end
    w_tgt_bin   = BW'(acc);
    w_tgt_valid = ok && (acc > START);
  end

  always_comb begin
    logic carry;
    w_count_inc = r_count;
    carry       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_count  = r_count;
    w_nxt_remain = r_remain;
    w_nxt_err    = r_err;
    if (i_start) begin
      if (w_tgt_valid) begin
        w_nxt_state  = S_COUNT;
        w_nxt_count  = W'(START);
        w_nxt_remain = w_tgt_bin - BW'(START);
        w_nxt_err    = 1'b0;
      end else begin
        w_nxt_state  = S_IDLE;
        w_nxt_err    = 1'b1;
      end
    end else if (r_inc) begin
      case (r_state)
        S_COUNT: begin
          w_nxt_count  = w_count_inc;
          w_nxt_remain = r_remain - BW'(1);
          if (r_remain == BW'(1)) w_nxt_state = S_DONE;
        end
        S_DONE:  w_nxt_err = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_remain   <= '0;
      r_err      <= 1'b0;
      r_pre_over <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_arm      <= '0;
      r_inc      <= 1'b0;
    end else begin
      r_sync1    <= i_change;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      r_arm      <= {r_arm[1:0], 1'b1};
      r_inc      <= w_edge;
      r_state    <= w_nxt_state;
      r_count    <= w_nxt_count;
      r_remain   <= w_nxt_remain;
      r_err      <= w_nxt_err;
      r_busy     <= (w_nxt_state == S_COUNT);
      r_done     <= (w_nxt_state == S_DONE);
      r_pre_over <= (w_nxt_state == S_COUNT) && (32'(w_nxt_remain) <= PRE_GAP);
    end
  end

  assign o_count    = r_count;
  assign o_pre_over = r_pre_over;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: tb/tb_bottle_batch_counter.sv
// tb/tb_bottle_batch_counter.sv - scoreboard bench for bottle_batch_counter
// Directed scenarios followed by randomized traffic, checked every cycle against an integer model.
module tb_bottle_batch_counter;

  localparam int DIGITS  = 2;
  localparam int START   = 1;
  localparam int PRE_GAP = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       change = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] count;
  logic       pre_over, done, busy, err;

  always #5 clk = ~clk;

  bottle_batch_counter #(.DIGITS(DIGITS), .START(START), .PRE_GAP(PRE_GAP)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_change(change),
    .i_target(target), .o_count(count), .o_pre_over(pre_over), .o_done(done),
    .o_busy(busy), .o_err(err)
  );

  typedef struct {
    int         cyc;
    logic [7:0] count;
    logic       pre, dn, bsy, er;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // Model: 0 idle, 1 counting, 2 done; count kept as a plain integer.
  int m_state = 0, m_cnt = 0, m_tgt = 0, m_err = 0;
  bit h_ch[5] = '{0, 0, 0, 0, 0};
  bit h_rs[5] = '{1, 1, 1, 1, 1};

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  task automatic chk(string name, int got, int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL cyc=%0d %s got=%0h want=%0h", cyc, name, got, want);
  endtask

  task automatic step();
    bit         r, s, ch, inc, ok, quiet;
    logic [7:0] t;
    int         tb;
    exp_t       e;
    r = reset_n; s = start; ch = change; t = target;
    @(posedge clk);
    cyc++;
    for (int i = 4; i > 0; i--) begin
      h_ch[i] = h_ch[i-1];
      h_rs[i] = h_rs[i-1];
    end
    h_ch[0] = ch;
    h_rs[0] = !r;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) if (h_rs[i]) quiet = 1'b0;
    // A bottle seen at edge N takes effect at edge N+3.
    inc = quiet && h_ch[3] && !h_ch[4];
    ok = 1'b1;
    tb = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (t[4*i +: 4] > 9) ok = 1'b0;
      tb = tb * 10 + int'(t[4*i +: 4]);
    end
    ok = ok && (tb > START);
    if (!r) begin
      m_state = 0; m_cnt = 0; m_err = 0;
    end else if (s) begin
      if (ok) begin
        m_state = 1; m_cnt = START; m_tgt = tb; m_err = 0;
      end else begin
        m_state = 0; m_err = 1;
      end
    end else if (inc) begin
      if (m_state == 1) begin
        m_cnt++;
        if (m_cnt == m_tgt) m_state = 2;
      end else if (m_state == 2) begin
        m_err = 1;
      end
    end
    e.cyc   = cyc;
    e.count = to_bcd(m_cnt);
    e.pre   = (m_state == 1) && (m_tgt - m_cnt <= PRE_GAP);
    e.dn    = (m_state == 2);
    e.bsy   = (m_state == 1);
    e.er    = (m_err != 0);
    sbq.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      chk("stale_entry", mon_e.cyc, cyc);
      chk("count", int'(count), int'(mon_e.count));
      chk("pre_over", int'(pre_over), int'(mon_e.pre));
      chk("done", int'(done), int'(mon_e.dn));
      chk("busy", int'(busy), int'(mon_e.bsy));
      chk("err", int'(err), int'(mon_e.er));
    end
  end

  task automatic pulse(int hi, int lo);
    change = 1'b1;
    repeat (hi) step();
    change = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_start(logic [7:0] t);
    target = t;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    int   roll;
    logic [3:0] lo_d, hi_d;
    // Reset with the sensor already high: release must not count a bottle.
    reset_n = 1'b0; change = 1'b1;
    step(); step();
    reset_n = 1'b1;
    repeat (10) step();
    change = 1'b0;
    repeat (3) step();

    // Full batch to 18 including the 09->10 carry, then an overrun and a restart.
    do_start(8'h18);
    repeat (17) pulse(2, 3);
    repeat (4) step();
    pulse(2, 5);
    do_start(8'h05);
    repeat (3) step();

    // Invalid targets: nibble above 9 and value not above START.
    do_start(8'h1A);
    step();
    do_start(8'h01);
    step();

    // One long steady level is a single bottle.
    do_start(8'h12);
    change = 1'b1;
    repeat (20) step();
    change = 1'b0;
    repeat (5) step();

    // Start lands on the same edge as a pending increment.
    change = 1'b1;
    step(); step(); step();
    target = 8'h07; start = 1'b1;
    step();
    start = 1'b0; change = 1'b0;
    repeat (5) step();

    // Small target: near-completion from the first counting cycle.
    do_start(8'h03);
    repeat (3) pulse(2, 2);
    repeat (3) step();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      roll = int'($urandom_range(0, 999));
      if (roll < 3) begin
        reset_n = 1'b0;
      end else begin
        reset_n = 1'b1;
      end
      if (roll >= 3 && roll < 10) begin
        lo_d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        hi_d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
        target = {hi_d, lo_d};
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) change = ~change;
      step();
    end
    reset_n = 1'b1; start = 1'b0; change = 1'b0;
    repeat (3) step();
    @(negedge clk);
    #1;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
